iecdrv_rom_sched: RTL and testbench

- Time-slot scheduler that shares one synchronous drive-ROM read port among up to 4 emulated 1541 drives, and lets a host loader write the same RAM-based ROM between frames.
- Each ph2_f strobe starts a frame. The block snapshots every drive address, applies 8K/16K/32K size masking, issues one read per drive in consecutive cycles, and returns per-drive data before the next phase.
- Sits between the drive cores and the shared ROM memory inside the multi-drive wrapper. Runs entirely in the drive clock domain.

---
 rtl/iecdrv_pkg.sv | 19 +
 rtl/iecdrv_tag_pipe.sv | 40 ++++
 rtl/iecdrv_rom_sched.sv | 139 +++++++++++++
 tb/tb_iecdrv_rom_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iecdrv_pkg.sv
// iecdrv_pkg: shared types, FSM states and ROM size masking for the drive-ROM scheduler
package iecdrv_pkg;

    localparam int MAX_DRIVES = 4;
    localparam int ROM_AW     = 15;
    localparam int ROM_DW     = 8;

    typedef logic [ROM_AW-1:0] rom_addr_t;
    typedef logic [ROM_DW-1:0] rom_data_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    // Bit14 only survives for a 32K image; bit13 survives for 16K/32K images
    // or when the standard 16K ROM is selected. Low 8K always passes through.
    function automatic rom_addr_t rom_mask(input rom_addr_t a, input logic [1:0] sz, input logic std);
        return {a[14] & sz[1], a[13] & (sz[0] | std), a[12:0]};
    endfunction

endpackage

// File: rtl/iecdrv_tag_pipe.sv
// iecdrv_tag_pipe: LAT-deep shift register carrying {valid, slot} alongside ROM reads
//   clk_i/reset_i      : clock, synchronous active-high reset
//   valid_i/slot_i     : tag entering with each issued read
//   valid_o/slot_o     : tag leaving when the matching ROM data is on mem_q
//   busy_o             : any read still in flight
module iecdrv_tag_pipe #(
    parameter int LAT = 1,
    parameter int SW  = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          valid_i,
    input  logic [SW-1:0] slot_i,
    output logic          valid_o,
    output logic [SW-1:0] slot_o,
    output logic          busy_o
);

    logic [LAT-1:0] valid_q;
    logic [SW-1:0]  slot_q [LAT];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            slot_q[0]  <= slot_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                slot_q[i]  <= slot_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign slot_o  = slot_q[LAT-1];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/iecdrv_rom_sched.sv
// iecdrv_rom_sched: time-slot scheduler sharing one drive-ROM read port among NDR drives
//   ph2_f_i            : frame-start strobe; snapshots drv_addr_i and stdrom_i
//   rom_sz_i/stdrom_i  : ROM size code {32K, >=16K} and standard-ROM select
//   drv_addr_i         : per-drive addresses, drive i at [i*AW +: AW]
//   drv_data_o/valid_o : per-drive read data (held) and one-cycle update pulses
//   mem_*              : shared ROM port (read strobe, write strobe, address, data)
//   host_*             : host loader write request / data / one-cycle ack
//   overrun_o          : sticky, ph2_f_i seen while a frame was still running
module iecdrv_rom_sched
    import iecdrv_pkg::*;
#(
    parameter int NDR    = 2,
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ph2_f_i,
    input  logic [1:0]        rom_sz_i,
    input  logic              stdrom_i,
    input  logic [NDR*AW-1:0] drv_addr_i,
    output logic [NDR*DW-1:0] drv_data_o,
    output logic [NDR-1:0]    drv_valid_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_we_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_q_i,
    input  logic              host_req_i,
    input  logic [AW-1:0]     host_addr_i,
    input  logic [DW-1:0]     host_data_i,
    output logic              host_ack_o,
    output logic              overrun_o
);

    localparam int SW = (NDR > 1) ? $clog2(NDR) : 1;

    state_e            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [AW-1:0]     snap_q [NDR];
    logic              std_q;
    logic [NDR*DW-1:0] data_q;
    logic [NDR-1:0]    valid_q;
    logic              ack_q;
    logic              ovr_q;
    logic              start;
    logic              grant;
    logic              issue;
    logic              tag_valid;
    logic              busy;
    logic [SW-1:0]     tag_slot;

    iecdrv_tag_pipe #(
        .LAT (RD_LAT),
        .SW  (SW)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (issue),
        .slot_i  (slot_q),
        .valid_o (tag_valid),
        .slot_o  (tag_slot),
        .busy_o  (busy)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        start       = 1'b0;
        grant       = 1'b0;
        issue       = 1'b0;
        mem_rd_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                // A frame start always wins over a pending host write.
                if (ph2_f_i) begin
                    start   = 1'b1;
                    slot_d  = '0;
                    state_d = ISSUE;
                end else if (host_req_i) begin
                    grant       = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = host_addr_i;
                    mem_wdata_o = host_data_i;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = AW'(rom_mask(rom_addr_t'(snap_q[slot_q]), rom_sz_i, std_q));
                slot_d     = slot_q + SW'(1);
                if (slot_q == SW'(NDR - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            slot_q  <= '0;
            std_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NDR; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ack_q   <= grant;
            valid_q <= '0;
            if (ph2_f_i && state_q != IDLE) ovr_q <= 1'b1;
            if (start) begin
                std_q <= stdrom_i;
                for (int i = 0; i < NDR; i++) snap_q[i] <= drv_addr_i[i*AW +: AW];
            end
            for (int i = 0; i < NDR; i++) begin
                if (tag_valid && tag_slot == SW'(i)) begin
                    valid_q[i]         <= 1'b1;
                    data_q[i*DW +: DW] <= mem_q_i;
                end
            end
        end
    end

    assign drv_data_o  = data_q;
    assign drv_valid_o = valid_q;
    assign host_ack_o  = ack_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// tb_iecdrv_rom_sched: directed self-checking bench for iecdrv_rom_sched (NDR=2/RD_LAT=1 and NDR=4/RD_LAT=2)
module tb_iecdrv_rom_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rom_sz;
    logic        stdrom;

    logic        ph2_0;
    logic [29:0] addr0;
    logic [15:0] data0;
    logic [1:0]  valid0;
    logic [14:0] mem_addr0;
    logic        rd0, we0;
    logic [7:0]  wdata0, q0;
    logic        hreq0;
    logic [14:0] haddr0;
    logic [7:0]  hdata0;
    logic        ack0, ovr0;

    logic        ph2_1;
    logic [59:0] addr1;
    logic [31:0] data1;
    logic [3:0]  valid1;
    logic [14:0] mem_addr1;
    logic        rd1, we1;
    logic [7:0]  wdata1, q1, q1a;
    logic        hreq1;
    logic [14:0] haddr1;
    logic [7:0]  hdata1;
    logic        ack1, ovr1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m0 [32768];
    bit         w0 [32768];

    always #5 clk = ~clk;

    function automatic logic [7:0] fv(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b0};
    endfunction

    iecdrv_rom_sched #(.NDR(2), .AW(15), .DW(8), .RD_LAT(1)) u0 (
        .clk_i(clk), .reset_i(reset), .ph2_f_i(ph2_0), .rom_sz_i(rom_sz), .stdrom_i(stdrom),
        .drv_addr_i(addr0), .drv_data_o(data0), .drv_valid_o(valid0), .mem_addr_o(mem_addr0),
        .mem_rd_o(rd0), .mem_we_o(we0), .mem_wdata_o(wdata0), .mem_q_i(q0), .host_req_i(hreq0),
        .host_addr_i(haddr0), .host_data_i(hdata0), .host_ack_o(ack0), .overrun_o(ovr0)
    );

    iecdrv_rom_sched #(.NDR(4), .AW(15), .DW(8), .RD_LAT(2)) u1 (
        .clk_i(clk), .reset_i(reset), .ph2_f_i(ph2_1), .rom_sz_i(rom_sz), .stdrom_i(stdrom),
        .drv_addr_i(addr1), .drv_data_o(data1), .drv_valid_o(valid1), .mem_addr_o(mem_addr1),
        .mem_rd_o(rd1), .mem_we_o(we1), .mem_wdata_o(wdata1), .mem_q_i(q1), .host_req_i(hreq1),
        .host_addr_i(haddr1), .host_data_i(hdata1), .host_ack_o(ack1), .overrun_o(ovr1)
    );

    always @(posedge clk) begin
        if (we0) begin
            m0[mem_addr0] <= wdata0;
            w0[mem_addr0] <= 1'b1;
        end
        q0 <= w0[mem_addr0] ? m0[mem_addr0] : fv(mem_addr0);
    end

    always @(posedge clk) begin
        q1a <= fv(mem_addr1);
        q1  <= q1a;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({valid0, data0, rd0, we0, mem_addr0, wdata0, ack0, ovr0} !== '0) begin
            n_fail++;
            $display("FAIL reset_u0 got %h required 0", {valid0, data0, rd0, we0, mem_addr0, wdata0, ack0, ovr0});
        end
        n_chk++;
        if ({valid1, data1, rd1, we1, mem_addr1, wdata1, ack1, ovr1} !== '0) begin
            n_fail++;
            $display("FAIL reset_u1 got %h required 0", {valid1, data1, rd1, we1, mem_addr1, wdata1, ack1, ovr1});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        step();
        addr0 = {15'h7FFF, 15'h4123};
        ph2_0 = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rd0 !== 1'b0) begin n_fail++; $display("FAIL basic_no_rd_at_ph2 got %b required 0", rd0); end
        step();
        ph2_0 = 1'b0;
        addr0 = '0;
        @(negedge clk);
        n_chk++;
        if ({rd0, mem_addr0} !== {1'b1, 15'h4123}) begin
            n_fail++; $display("FAIL basic_slot0 got rd=%b addr=%h required rd=1 addr=4123", rd0, mem_addr0);
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({rd0, mem_addr0} !== {1'b1, 15'h7FFF}) begin
            n_fail++; $display("FAIL basic_slot1 got rd=%b addr=%h required rd=1 addr=7fff", rd0, mem_addr0);
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, data0[7:0]} !== {2'b01, fv(15'h4123)}) begin
            n_fail++; $display("FAIL basic_cap0 got v=%b d=%h required v=01 d=%h", valid0, data0[7:0], fv(15'h4123));
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, data0} !== {2'b10, fv(15'h7FFF), fv(15'h4123)}) begin
            n_fail++; $display("FAIL basic_cap1 got v=%b d=%h required v=10 d=%h%h", valid0, data0, fv(15'h7FFF), fv(15'h4123));
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, rd0, we0} !== 4'b0) begin
            n_fail++; $display("FAIL basic_end got v=%b rd=%b we=%b required 0", valid0, rd0, we0);
        end
    endtask

    task automatic test_mask();
        logic [1:0]  sz_t [3] = '{2'b00, 2'b01, 2'b00};
        logic        st_t [3] = '{1'b0, 1'b0, 1'b1};
        logic [14:0] ex_t [3] = '{15'h1ABC, 15'h3ABC, 15'h3ABC};
        for (int i = 0; i < 3; i++) begin
            step();
            addr0  = {15'h0000, 15'h7ABC};
            rom_sz = sz_t[i];
            stdrom = st_t[i];
            ph2_0  = 1'b1;
            step();
            ph2_0  = 1'b0;
            stdrom = ~st_t[i];
            @(negedge clk);
            n_chk++;
            if (mem_addr0 !== ex_t[i]) begin
                n_fail++; $display("FAIL mask_addr[%0d] got %h required %h", i, mem_addr0, ex_t[i]);
            end
            step();
            step();
            @(negedge clk);
            n_chk++;
            if ({valid0, data0[7:0]} !== {2'b01, fv(ex_t[i])}) begin
                n_fail++; $display("FAIL mask_data[%0d] got v=%b d=%h required v=01 d=%h", i, valid0, data0[7:0], fv(ex_t[i]));
            end
            step();
            step();
        end
        rom_sz = 2'b11;
        stdrom = 1'b0;
    endtask

    task automatic test_host_during_frame();
        step();
        addr0 = '0;
        ph2_0 = 1'b1;
        step();
        ph2_0 = 1'b0;
        step();
        hreq0  = 1'b1;
        haddr0 = 15'h0123;
        hdata0 = 8'h5A;
        @(negedge clk);
        n_chk++;
        if ({we0, rd0} !== 2'b01) begin n_fail++; $display("FAIL host_wait_issue got we=%b rd=%b required we=0 rd=1", we0, rd0); end
        for (int c = 3; c <= 4; c++) begin
            step();
            @(negedge clk);
            n_chk++;
            if (we0 !== 1'b0) begin n_fail++; $display("FAIL host_wait_drain[%0d] got we=%b required 0", c, we0); end
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({we0, rd0, mem_addr0, wdata0, ack0} !== {1'b1, 1'b0, 15'h0123, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL host_write got we=%b rd=%b a=%h d=%h ack=%b required we=1 rd=0 a=0123 d=5a ack=0", we0, rd0, mem_addr0, wdata0, ack0);
        end
        step();
        hreq0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ack0, we0} !== 2'b10) begin n_fail++; $display("FAIL host_ack got ack=%b we=%b required ack=1 we=0", ack0, we0); end
        step();
        @(negedge clk);
        n_chk++;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL host_ack_pulse got %b required 0", ack0); end
        step();
        addr0 = {15'h0000, 15'h0123};
        ph2_0 = 1'b1;
        step();
        ph2_0 = 1'b0;
        step();
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, data0[7:0]} !== {2'b01, 8'h5A}) begin
            n_fail++; $display("FAIL host_readback got v=%b d=%h required v=01 d=5a", valid0, data0[7:0]);
        end
        step();
        step();
    endtask

    task automatic test_ph2_host_same();
        step();
        addr0  = '0;
        hreq0  = 1'b1;
        haddr0 = 15'h0456;
        hdata0 = 8'hA5;
        ph2_0  = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({we0, rd0} !== 2'b00) begin n_fail++; $display("FAIL same_no_grant got we=%b rd=%b required 00", we0, rd0); end
        step();
        ph2_0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({we0, rd0} !== 2'b01) begin n_fail++; $display("FAIL same_frame_first got we=%b rd=%b required we=0 rd=1", we0, rd0); end
        repeat (3) step();
        @(negedge clk);
        n_chk++;
        if (we0 !== 1'b0) begin n_fail++; $display("FAIL same_wait_drain got we=%b required 0", we0); end
        step();
        @(negedge clk);
        n_chk++;
        if ({we0, mem_addr0, wdata0} !== {1'b1, 15'h0456, 8'hA5}) begin
            n_fail++; $display("FAIL same_write got we=%b a=%h d=%h required we=1 a=0456 d=a5", we0, mem_addr0, wdata0);
        end
        step();
        hreq0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ack0, ovr0} !== 2'b10) begin n_fail++; $display("FAIL same_ack got ack=%b ovr=%b required ack=1 ovr=0", ack0, ovr0); end
        step();
    endtask

    task automatic test_overrun();
        logic [14:0] ea [4] = '{15'h0011, 15'h2222, 15'h4333, 15'h7444};
        logic [3:0]  ev;
        step();
        addr1 = {15'h7444, 15'h4333, 15'h2222, 15'h0011};
        ph2_1 = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            step();
            ph2_1 = (j == 2);
            if (j == 2) addr1 = '0;
            @(negedge clk);
            if (j <= 4) begin
                n_chk++;
                if ({rd1, mem_addr1} !== {1'b1, ea[j-1]}) begin
                    n_fail++; $display("FAIL ovr_addr[%0d] got rd=%b a=%h required rd=1 a=%h", j, rd1, mem_addr1, ea[j-1]);
                end
            end
            ev = (j >= 4 && j <= 7) ? 4'(1 << (j - 4)) : 4'b0;
            n_chk++;
            if (valid1 !== ev) begin n_fail++; $display("FAIL ovr_valid[%0d] got %b required %b", j, valid1, ev); end
            if (j == 2 || j == 3) begin
                n_chk++;
                if (ovr1 !== (j == 3)) begin n_fail++; $display("FAIL ovr_flag[%0d] got %b required %b", j, ovr1, j == 3); end
            end
        end
        n_chk++;
        if (data1 !== {fv(15'h7444), fv(15'h4333), fv(15'h2222), fv(15'h0011)}) begin
            n_fail++; $display("FAIL ovr_data got %h required %h%h%h%h", data1, fv(15'h7444), fv(15'h4333), fv(15'h2222), fv(15'h0011));
        end
        step();
        addr1 = {15'h0001, 15'h0002, 15'h0003, 15'h0004};
        ph2_1 = 1'b1;
        step();
        ph2_1 = 1'b0;
        repeat (8) step();
        @(negedge clk);
        n_chk++;
        if ({ovr1, data1} !== {1'b1, fv(15'h0001), fv(15'h0002), fv(15'h0003), fv(15'h0004)}) begin
            n_fail++; $display("FAIL ovr_sticky got ovr=%b d=%h required ovr=1", ovr1, data1);
        end
    endtask

    task automatic test_reset_midframe();
        step();
        addr0 = {15'h7FFF, 15'h4123};
        ph2_0 = 1'b1;
        step();
        ph2_0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rd0 !== 1'b1) begin n_fail++; $display("FAIL rst_first_rd got %b required 1", rd0); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({valid0, data0, rd0, we0, mem_addr0, wdata0, ack0, ovr0, ovr1} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs got %h required 0", {valid0, data0, rd0, we0, mem_addr0, wdata0, ack0, ovr0, ovr1});
        end
        step();
        @(negedge clk);
        n_chk++;
        if (valid0 !== 2'b00) begin n_fail++; $display("FAIL rst_no_valid got %b required 00", valid0); end
        step();
        ph2_0 = 1'b1;
        step();
        ph2_0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({rd0, mem_addr0} !== {1'b1, 15'h4123}) begin
            n_fail++; $display("FAIL rst_refresh_addr got rd=%b a=%h required rd=1 a=4123", rd0, mem_addr0);
        end
        step();
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, data0[7:0]} !== {2'b01, fv(15'h4123)}) begin
            n_fail++; $display("FAIL rst_refresh_cap0 got v=%b d=%h required v=01 d=%h", valid0, data0[7:0], fv(15'h4123));
        end
        step();
        @(negedge clk);
        n_chk++;
        if ({valid0, data0[15:8]} !== {2'b10, fv(15'h7FFF)}) begin
            n_fail++; $display("FAIL rst_refresh_cap1 got v=%b d=%h required v=10 d=%h", valid0, data0[15:8], fv(15'h7FFF));
        end
    endtask

    initial begin
        reset  = 1'b1;
        rom_sz = 2'b11;
        stdrom = 1'b0;
        ph2_0  = 1'b0;
        addr0  = '0;
        hreq0  = 1'b0;
        haddr0 = '0;
        hdata0 = '0;
        ph2_1  = 1'b0;
        addr1  = '0;
        hreq1  = 1'b0;
        haddr1 = '0;
        hdata1 = '0;
        test_reset();
        repeat (5) step();
        test_basic();
        test_mask();
        test_host_during_frame();
        test_ph2_host_same();
        test_overrun();
        test_reset_midframe();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_chk);
        $fatal(1);
    end

endmodule
